// File: rtl/rng_pkg.sv
// Shared constants and the xorshift32 step function for the card-draw generator.
package rng_pkg;

    localparam int unsigned RNG_W     = 32;
    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned CARD_W    = 6;

    localparam logic [RNG_W-1:0] DEFAULT_SEED = 32'hDEADBEEF;

    // Zero is a fixed point of this map; callers that hold state must keep it out.
    function automatic logic [RNG_W-1:0] xorshift32(input logic [RNG_W-1:0] x);
        logic [RNG_W-1:0] x1;
        logic [RNG_W-1:0] x2;
        x1 = x  ^ (x  << 5'd13);
        x2 = x1 ^ (x1 >> 5'd17);
        return x2 ^ (x2 << 5'd5);
    endfunction

endpackage

// File: rtl/rng_core_if.sv
// Operand/result and control bundle between the generator and its user.
interface rng_core_if;

    logic [rng_pkg::RNG_W-1:0]  current_i;
    logic [rng_pkg::RNG_W-1:0]  next_o;
    logic                       seed_load_i;
    logic [rng_pkg::RNG_W-1:0]  seed_i;
    logic                       step_i;
    logic [rng_pkg::RNG_W-1:0]  state_o;
    logic [rng_pkg::CARD_W-1:0] card_o;

    modport slave (
        input  current_i,
        input  seed_load_i,
        input  seed_i,
        input  step_i,
        output next_o,
        output state_o,
        output card_o
    );

    modport master (
        output current_i,
        output seed_load_i,
        output seed_i,
        output step_i,
        input  next_o,
        input  state_o,
        input  card_o
    );

endinterface

// File: rtl/rng_mod52.sv
// Remainder of a W-bit value by a small constant, built as an MSB-first
// shift-subtract chain so no general divider is inferred.
module rng_mod52 #(
    parameter int unsigned W       = 32,
    parameter int unsigned DIVISOR = 52,
    parameter int unsigned REM_W   = 6
) (
    input  logic [W-1:0]     value_i,
    output logic [REM_W-1:0] rem_o
);

    localparam int unsigned RW = REM_W + 1;
    localparam logic [RW-1:0] DIV_C = RW'(DIVISOR);

    logic [RW-1:0] rem_s;

    // Partial remainder stays below DIVISOR, so one conditional subtract per bit suffices.
    always_comb begin
        rem_s = {RW{1'b0}};
        for (int i = W - 1; i >= 0; i--) begin
            rem_s = {rem_s[REM_W-1:0], value_i[i]};
            if (rem_s >= DIV_C) begin
                rem_s = rem_s - DIV_C;
            end else begin
                rem_s = rem_s;
            end
        end
        rem_o = rem_s[REM_W-1:0];
    end

endmodule

// File: rtl/rng_core.sv
// xorshift32 generator: free combinational step on current_i plus a seeded
// state register that advances on request and feeds a mod-52 card index.
module rng_core
    import rng_pkg::*;
#(
    parameter logic [RNG_W-1:0] SEED_INIT = DEFAULT_SEED
) (
    input  logic      clk,
    input  logic      rst_n,
    rng_core_if.slave bus
);

    logic [RNG_W-1:0]  state_q;
    logic [RNG_W-1:0]  state_d;
    logic [RNG_W-1:0]  step_s;
    logic [CARD_W-1:0] card_s;

    assign bus.next_o = xorshift32(bus.current_i);
    assign step_s     = xorshift32(state_q);

    // Seed load beats step; a zero seed would lock the generator, so substitute the default.
    always_comb begin
        state_d = state_q;
        if (bus.seed_load_i) begin
            if (bus.seed_i == {RNG_W{1'b0}}) begin
                state_d = SEED_INIT;
            end else begin
                state_d = bus.seed_i;
            end
        end else if (bus.step_i) begin
            state_d = step_s;
        end else begin
            state_d = state_q;
        end
    end

    // Generator state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    rng_mod52 #(
        .W       (RNG_W),
        .DIVISOR (DECK_SIZE),
        .REM_W   (CARD_W)
    ) u_mod52 (
        .value_i (state_q),
        .rem_o   (card_s)
    );

    assign bus.state_o = state_q;
    assign bus.card_o  = card_s;

endmodule

// File: tb/tb_rng_core.sv
// Directed bench for rng_core: a reference model of the generator rules is
// compared every cycle, with literal expectations pinning the model.
module tb_rng_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] mdl_q;
    logic [31:0] prev_next;
    logic [31:0] seq [0:9];

    rng_core_if bus_if ();

    rng_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_f(input logic [31:0] x);
        logic [31:0] a;
        logic [31:0] b;
        a = x ^ (x << 13);
        b = a ^ (a >> 17);
        return b ^ (b << 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model of the state register rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdl_q <= 32'hDEADBEEF;
        else if (bus_if.seed_load_i)
            mdl_q <= (bus_if.seed_i == 32'd0) ? 32'hDEADBEEF : bus_if.seed_i;
        else if (bus_if.step_i)
            mdl_q <= ref_f(mdl_q);
        else
            mdl_q <= mdl_q;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", bus_if.state_o, mdl_q);
            check("card", {26'd0, bus_if.card_o}, mdl_q % 32'd52);
            check("card_range", {31'd0, (bus_if.card_o < 6'd52)}, 32'd1);
            check("next", bus_if.next_o, ref_f(bus_if.current_i));
        end
    end

    initial begin
        bus_if.current_i   = 32'd0;
        bus_if.seed_load_i = 1'b0;
        bus_if.seed_i      = 32'd0;
        bus_if.step_i      = 1'b0;

        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        check("rst_state", bus_if.state_o, 32'hDEADBEEF);
        check("rst_card", {26'd0, bus_if.card_o}, 32'd51);

        bus_if.current_i = 32'h00000001;
        #1;
        check("comb_next_1", bus_if.next_o, 32'h00042021);
        bus_if.current_i = 32'd0;
        #1;
        check("comb_next_0", bus_if.next_o, 32'd0);

        tick();
        rst_n = 1'b1;

        // 100-step chain; each new state must equal the prior combinational next.
        bus_if.step_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus_if.current_i = bus_if.state_o;
            #1;
            prev_next = bus_if.next_o;
            tick();
            check("chain", bus_if.state_o, prev_next);
            if (i < 10) seq[i] = bus_if.state_o;
        end
        bus_if.step_i = 1'b0;
        check("chain_first", seq[0], ref_f(32'hDEADBEEF));

        bus_if.seed_load_i = 1'b1;
        bus_if.seed_i      = 32'h00000001;
        tick();
        bus_if.seed_load_i = 1'b0;
        check("seed1_state", bus_if.state_o, 32'h00000001);
        bus_if.step_i = 1'b1;
        tick();
        bus_if.step_i = 1'b0;
        check("seed1_step", bus_if.state_o, 32'h00042021);
        check("seed1_card", {26'd0, bus_if.card_o}, 32'd21);

        bus_if.seed_load_i = 1'b1;
        bus_if.seed_i      = 32'd0;
        bus_if.step_i      = 1'b1;
        tick();
        bus_if.seed_load_i = 1'b0;
        bus_if.step_i      = 1'b0;
        check("zero_seed_prio", bus_if.state_o, 32'hDEADBEEF);

        bus_if.step_i = 1'b1;
        repeat (3) tick();
        bus_if.step_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold", bus_if.state_o, seq[2]);
        end

        bus_if.step_i = 1'b1;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("midrun_rst_state", bus_if.state_o, 32'hDEADBEEF);
        check("midrun_rst_card", {26'd0, bus_if.card_o}, 32'd51);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("replay", bus_if.state_o, seq[i]);
        end
        bus_if.step_i = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
